// File: rtl/ofdm_pkg.sv
// Shared OFDM constants, the IFFT frame sequencer state type and the
// null-carrier index helper.
package ofdm_pkg;

    localparam int          NFFT        = 16;
    localparam logic [23:0] CFG_DEFAULT = 24'h000204;
    localparam int          SAMPLE_W    = 16;

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_CFG      = 2'd1,
        ST_STREAM   = 2'd2
    } state_t;

    // DC (index 0) and Nyquist (index nfft/2) carry no data.
    function automatic logic is_null_idx(input int idx, input int nfft);
        return (idx == 0) || (idx == nfft / 2);
    endfunction

endpackage

// File: rtl/ifft_frame_ctrl.sv
// Sequencer between the QAM mapper and the IFFT core: resets and configures
// the core, builds NFFT-point frames with nulls at DC and Nyquist, forwards
// the core output downstream and flags framing errors.
//
// Handshakes: a transfer happens on a rising edge where tvalid and tready
// are both high; a source holds tvalid and tdata stable until that edge.
module ifft_frame_ctrl #(
    parameter int          NFFT        = ofdm_pkg::NFFT,
    parameter logic [23:0] CFG_DEFAULT = ofdm_pkg::CFG_DEFAULT
) (
    input  logic        aclk,
    input  logic        rst,
    input  logic [23:0] cfg_word,
    input  logic        cfg_update,
    input  logic        in_tvalid,
    output logic        in_tready,
    input  logic [31:0] in_tdata,
    output logic        fft_aresetn,
    output logic        fft_cfg_tvalid,
    input  logic        fft_cfg_tready,
    output logic [23:0] fft_cfg_tdata,
    output logic        fft_s_tvalid,
    input  logic        fft_s_tready,
    output logic [31:0] fft_s_tdata,
    output logic        fft_s_tlast,
    input  logic        fft_m_tvalid,
    output logic        fft_m_tready,
    input  logic [31:0] fft_m_tdata,
    input  logic        fft_m_tlast,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic [31:0] out_tdata,
    output logic        out_tlast,
    input  logic        ev_tlast_unexpected,
    input  logic        ev_tlast_missing,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        err,
    output logic [1:0]  dbg_state
);
    import ofdm_pkg::*;

    localparam int               IDX_W    = $clog2(NFFT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFFT - 1);

    state_t           state_q;
    logic [1:0]       hold_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] ocnt_q;
    logic [23:0]      pend_q;
    logic [23:0]      cfg_data_q;
    logic             upd_pend_q;
    logic             aresetn_q;
    logic             cfg_valid_q;
    logic             err_q;
    logic [15:0]      frame_cnt_q;
    logic             s_hs;
    logic             o_hs;

    // Core input mux: nulls at DC/Nyquist, mapper samples elsewhere.
    always_comb begin
        in_tready    = 1'b0;
        fft_s_tvalid = 1'b0;
        fft_s_tdata  = '0;
        fft_s_tlast  = 1'b0;
        if (state_q == ST_STREAM) begin
            fft_s_tlast = (idx_q == LAST_IDX);
            if (is_null_idx(int'(idx_q), NFFT)) begin
                fft_s_tvalid = 1'b1;
            end else begin
                fft_s_tvalid = in_tvalid;
                fft_s_tdata  = in_tdata;
                in_tready    = fft_s_tready;
            end
        end
    end

    assign s_hs           = fft_s_tvalid & fft_s_tready;
    assign o_hs           = fft_m_tvalid & out_tready;
    assign busy           = (idx_q != '0);
    assign fft_aresetn    = aresetn_q;
    assign fft_cfg_tvalid = cfg_valid_q;
    assign fft_cfg_tdata  = cfg_data_q;
    assign out_tvalid     = fft_m_tvalid;
    assign out_tdata      = fft_m_tdata;
    assign out_tlast      = fft_m_tlast;
    assign fft_m_tready   = out_tready;
    assign frame_cnt      = frame_cnt_q;
    assign err            = err_q;
    assign dbg_state      = state_q;

    // Sequencer FSM: core reset hold, config handshake, frame streaming.
    // The pending word is copied into cfg_data_q on entry to CFG so that a
    // cfg_update arriving during the handshake cannot disturb the offered
    // word; such an update stays pending for the next frame boundary.
    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q     <= ST_RST_HOLD;
            hold_q      <= 2'd0;
            idx_q       <= '0;
            pend_q      <= CFG_DEFAULT;
            upd_pend_q  <= 1'b0;
            aresetn_q   <= 1'b0;
            cfg_valid_q <= 1'b0;
            cfg_data_q  <= CFG_DEFAULT;
        end else begin
            if (cfg_update) begin
                pend_q     <= cfg_word;
                upd_pend_q <= 1'b1;
            end
            case (state_q)
                ST_RST_HOLD: begin
                    if (hold_q == 2'd2) begin
                        state_q     <= ST_CFG;
                        aresetn_q   <= 1'b1;
                        cfg_valid_q <= 1'b1;
                        cfg_data_q  <= pend_q;
                        if (!cfg_update) upd_pend_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q + 2'd1;
                    end
                end
                ST_CFG: begin
                    if (fft_cfg_tready) begin
                        cfg_valid_q <= 1'b0;
                        state_q     <= ST_STREAM;
                        idx_q       <= '0;
                    end
                end
                ST_STREAM: begin
                    if (s_hs) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q <= '0;
                            if (upd_pend_q) begin
                                state_q     <= ST_CFG;
                                cfg_valid_q <= 1'b1;
                                cfg_data_q  <= pend_q;
                                if (!cfg_update) upd_pend_q <= 1'b0;
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_RST_HOLD;
            endcase
        end
    end

    // Output framing checker: tlast must land exactly on sample NFFT-1.
    always_ff @(posedge aclk) begin
        if (rst) begin
            ocnt_q      <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (ev_tlast_unexpected || ev_tlast_missing) err_q <= 1'b1;
            if (o_hs) begin
                if (fft_m_tlast != (ocnt_q == LAST_IDX)) err_q <= 1'b1;
                if (fft_m_tlast) frame_cnt_q <= frame_cnt_q + 16'd1;
                if (fft_m_tlast || (ocnt_q == LAST_IDX)) ocnt_q <= '0;
                else                                     ocnt_q <= ocnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ifft_frame_ctrl.sv
// Bench for ifft_frame_ctrl: random mapper/core/downstream traffic checked
// against a frame-level model of the expected core input stream.
module tb_ifft_frame_ctrl;

  localparam int          NFFT    = 16;
  localparam logic [23:0] CFG_DEF = 24'h000204;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic rst  = 1'b1;
  always #5 aclk = ~aclk;

  logic [23:0] cfg_word = '0;
  logic        cfg_update = 1'b0;
  logic        in_tvalid = 1'b0;
  logic        in_tready;
  logic [31:0] in_tdata = '0;
  logic        fft_aresetn;
  logic        fft_cfg_tvalid;
  logic        fft_cfg_tready = 1'b0;
  logic [23:0] fft_cfg_tdata;
  logic        fft_s_tvalid;
  logic        fft_s_tready = 1'b1;
  logic [31:0] fft_s_tdata;
  logic        fft_s_tlast;
  logic        fft_m_tvalid = 1'b0;
  logic        fft_m_tready;
  logic [31:0] fft_m_tdata = '0;
  logic        fft_m_tlast = 1'b0;
  logic        out_tvalid;
  logic        out_tready = 1'b1;
  logic [31:0] out_tdata;
  logic        out_tlast;
  logic        ev_tlast_unexpected = 1'b0;
  logic        ev_tlast_missing = 1'b0;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        err;
  logic [1:0]  dbg_state;

  ifft_frame_ctrl dut (
    .aclk(aclk), .rst(rst), .cfg_word(cfg_word), .cfg_update(cfg_update),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
    .fft_aresetn(fft_aresetn),
    .fft_cfg_tvalid(fft_cfg_tvalid), .fft_cfg_tready(fft_cfg_tready), .fft_cfg_tdata(fft_cfg_tdata),
    .fft_s_tvalid(fft_s_tvalid), .fft_s_tready(fft_s_tready), .fft_s_tdata(fft_s_tdata), .fft_s_tlast(fft_s_tlast),
    .fft_m_tvalid(fft_m_tvalid), .fft_m_tready(fft_m_tready), .fft_m_tdata(fft_m_tdata), .fft_m_tlast(fft_m_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata), .out_tlast(out_tlast),
    .ev_tlast_unexpected(ev_tlast_unexpected), .ev_tlast_missing(ev_tlast_missing),
    .busy(busy), .frame_cnt(frame_cnt), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];        // mapper samples accepted, awaiting the core
  logic [23:0] exp_cfg_q[$];    // config words the core should receive
  int          pos = 0;         // model position within the core frame
  int          frames_in = 0;
  int          cfg_cnt = 0;
  bit          rdy_rand = 1'b0;
  int          stall_pos = -1;
  int          stall_left = 0;
  bit          stop_map = 1'b0;
  int          exp_frames = 0;
  bit          exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // ---------------- monitor: core input/config vs model ----------------
  initial begin
    forever begin
      @(negedge aclk);
      #4;
      if (rst) begin
        pos = 0;
        exp_q.delete();
      end else begin
        if (in_tvalid && in_tready) exp_q.push_back(in_tdata);
        if (fft_cfg_tvalid) check("cfg_at_boundary", 32'(pos), 32'd0);
        if (fft_cfg_tvalid && fft_cfg_tready) begin
          if (exp_cfg_q.size() == 0) check("cfg_extra", 32'd1, 32'd0);
          else check("cfg_word", 32'(fft_cfg_tdata), 32'(exp_cfg_q.pop_front()));
          cfg_cnt++;
        end
        if (fft_s_tvalid && fft_s_tready) begin
          if (pos == 0 || pos == NFFT / 2) begin
            check("core_null", fft_s_tdata, 32'd0);
            check("null_rdy", 32'(in_tready), 32'd0);
          end else if (exp_q.size() == 0) begin
            check("core_underrun", 32'd1, 32'd0);
          end else begin
            check("core_data", fft_s_tdata, exp_q.pop_front());
          end
          check("core_tlast", 32'(fft_s_tlast), 32'(pos == NFFT - 1));
          check("busy", 32'(busy), 32'(pos != 0));
          if (pos == NFFT - 1) begin
            pos = 0;
            frames_in++;
          end else begin
            pos++;
          end
        end
      end
    end
  end

  // ---------------- core input ready driver ----------------
  initial begin
    forever begin
      @(negedge aclk);
      if (stall_left > 0 && pos == stall_pos) begin
        fft_s_tready = 1'b0;
        stall_left--;
      end else if (rdy_rand) begin
        fft_s_tready = ($urandom_range(3) != 0);
      end else begin
        fft_s_tready = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic map_send(input int n, input bit fixed, input int gap_at, input int gap_pct);
    int k = 0;
    int guard = 0;
    int gap_cycles = 2;
    bit pending = 1'b0;
    while (k < n && !stop_map) begin
      @(negedge aclk);
      guard++;
      if (guard > 3000) begin
        check("map_timeout", 32'd1, 32'd0);
        break;
      end
      if (!pending) begin
        if (k == gap_at && gap_cycles > 0) begin
          gap_cycles--;
          in_tvalid = 1'b0;
          continue;
        end
        if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
          in_tvalid = 1'b0;
          continue;
        end
        in_tdata  = fixed ? 32'h7fe07fe0 : $urandom;
        in_tvalid = 1'b1;
        pending   = 1'b1;
      end
      #4;
      if (in_tvalid && in_tready) begin
        pending = 1'b0;
        k++;
      end
    end
    @(negedge aclk);
    in_tvalid = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    int t = 0;
    while (pos != p && t < 500) begin
      @(negedge aclk);
      #4;
      t++;
    end
    if (pos != p) check("wait_pos_timeout", 32'(pos), 32'(p));
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (frames_in < n && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    check("frames_in", 32'(frames_in), 32'(n));
    check("map_q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_cfg(input int n);
    int t = 0;
    while (cfg_cnt < n && t < 200) begin
      @(negedge aclk);
      t++;
    end
    check("cfg_count", 32'(cfg_cnt), 32'(n));
  endtask

  task automatic reset_dut();
    @(negedge aclk);
    rst = 1'b1;
    @(negedge aclk);
    check("rst_aresetn", 32'(fft_aresetn), 32'd0);
    check("rst_cfg_valid", 32'(fft_cfg_tvalid), 32'd0);
    check("rst_s_valid", 32'(fft_s_tvalid), 32'd0);
    check("rst_s_tlast", 32'(fft_s_tlast), 32'd0);
    check("rst_s_tdata", fft_s_tdata, 32'd0);
    check("rst_in_ready", 32'(in_tready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    exp_frames = 0;
    exp_err    = 1'b0;
    exp_cfg_q.push_back(CFG_DEF);
    @(negedge aclk);
    rst = 1'b0;
    @(negedge aclk);
    check("aresetn_c1", 32'(fft_aresetn), 32'd0);
    @(negedge aclk);
    check("aresetn_c2", 32'(fft_aresetn), 32'd0);
    @(negedge aclk);
    check("aresetn_c3", 32'(fft_aresetn), 32'd1);
    check("cfg_valid_c3", 32'(fft_cfg_tvalid), 32'd1);
  endtask

  // Downstream-side frame from a model core; len != NFFT is a framing error.
  task automatic out_frame(input int len);
    int k = 0;
    int guard = 0;
    bit pend = 1'b0;
    while (k < len && guard < 1000) begin
      @(negedge aclk);
      guard++;
      out_tready = ($urandom_range(3) != 0);
      if (!pend) begin
        if ($urandom_range(3) == 0) begin
          fft_m_tvalid = 1'b0;
        end else begin
          fft_m_tvalid = 1'b1;
          fft_m_tdata  = $urandom;
          fft_m_tlast  = (k == len - 1);
          pend = 1'b1;
        end
      end
      #4;
      check("m_tready", 32'(fft_m_tready), 32'(out_tready));
      if (fft_m_tvalid && out_tready) begin
        check("out_valid", 32'(out_tvalid), 32'd1);
        check("out_data", out_tdata, fft_m_tdata);
        check("out_tlast", 32'(out_tlast), 32'(k == len - 1));
        pend = 1'b0;
        k++;
      end
    end
    if (k < len) check("out_timeout", 32'(k), 32'(len));
    exp_frames++;
    if (len != NFFT) exp_err = 1'b1;
    @(negedge aclk);
    fft_m_tvalid = 1'b0;
    fft_m_tlast  = 1'b0;
    out_tready   = 1'b1;
    check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("err", 32'(err), 32'(exp_err));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    // Reset release with a stalled config channel.
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("cfg_stall_valid", 32'(fft_cfg_tvalid), 32'd1);
      check("cfg_stall_data", 32'(fft_cfg_tdata), 32'(CFG_DEF));
    end
    fft_cfg_tready = 1'b1;
    @(negedge aclk);
    check("first_null_valid", 32'(fft_s_tvalid), 32'd1);
    check("first_null_data", fft_s_tdata, 32'd0);
    check("first_null_rdy", 32'(in_tready), 32'd0);
    check("cfg_done_valid", 32'(fft_cfg_tvalid), 32'd0);

    // One frame of constant mapper data.
    map_send(NFFT - 2, 1'b1, -1, 0);
    wait_frames(1);

    // Core backpressure at idx 5 plus an upstream gap at idx 10.
    stall_pos  = 5;
    stall_left = 3;
    map_send(NFFT - 2, 1'b0, 8, 0);
    wait_frames(2);

    // Random traffic on both sides.
    rdy_rand = 1'b1;
    for (int f = 0; f < 3; f++) begin
      map_send(NFFT - 2, 1'b0, -1, 30);
      wait_frames(3 + f);
    end

    // Reconfiguration requested mid-frame.
    fork
      map_send(NFFT - 2, 1'b0, -1, 20);
      begin
        wait_pos(6);
        @(negedge aclk);
        cfg_word   = 24'h000304;
        cfg_update = 1'b1;
        exp_cfg_q.push_back(24'h000304);
        @(negedge aclk);
        cfg_update = 1'b0;
      end
    join
    wait_frames(6);
    map_send(NFFT - 2, 1'b0, -1, 20);
    wait_frames(7);
    check("cfg_after_reconfig", 32'(cfg_cnt), 32'd2);
    check("cfg_q_empty", 32'(exp_cfg_q.size()), 32'd0);
    rdy_rand = 1'b0;

    // Output path framing and frame counter.
    out_frame(NFFT);
    out_frame(NFFT);
    out_frame(12);
    out_frame(NFFT);

    // Reset in the middle of a frame.
    fork
      map_send(NFFT - 2, 1'b0, -1, 0);
      begin
        wait_pos(9);
        stop_map = 1'b1;
        reset_dut();
      end
    join
    stop_map = 1'b0;
    wait_cfg(3);
    frames_in = 0;
    map_send(NFFT - 2, 1'b0, -1, 10);
    wait_frames(1);
    out_frame(NFFT);

    // Core event inputs, each from a clean reset.
    @(negedge aclk);
    ev_tlast_missing = 1'b1;
    @(negedge aclk);
    ev_tlast_missing = 1'b0;
    check("ev_missing_err", 32'(err), 32'd1);
    reset_dut();
    wait_cfg(4);
    @(negedge aclk);
    ev_tlast_unexpected = 1'b1;
    @(negedge aclk);
    ev_tlast_unexpected = 1'b0;
    check("ev_unexpected_err", 32'(err), 32'd1);
    @(negedge aclk);
    check("err_sticky", 32'(err), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
